// File: rtl/bcd_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_alu_pkg
//  Description : Shared types and helpers for the digit-serial BCD ALU:
//                opcode and FSM state enums, the BCD nine constant, opcode
//                decode and nine's-complement of a single digit.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b010,
        OP_PASS = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        RECOMP = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Every opcode other than ADD/SUB behaves as PASS.
    function automatic op_t decode_op(input logic [2:0] code);
        case (code)
            3'b000:  return OP_ADD;
            3'b010:  return OP_SUB;
            default: return OP_PASS;
        endcase
    endfunction

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_NINE - d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adder
//  Description : Combinational single-digit BCD adder, a + b + cin with the
//                +6 decimal correction when the binary sum exceeds nine.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adder
    import bcd_alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] corrected;

    // Binary add, then fold back into a decimal digit with a carry.
    always_comb begin
        raw       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        corrected = raw + 5'd6;
        if (raw > {1'b0, BCD_NINE}) begin
            sum  = corrected[3:0];
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_alu
//  Description : Digit-serial sign-magnitude BCD add/subtract unit. One digit
//                per clock, LSD first, with nine's-complement subtraction and
//                a recomplement pass when the magnitude difference goes
//                negative. Flags overflow and invalid (non-BCD) operands.
//                Optional macro BCD_SATURATE_EN: clamp magnitude to all nines
//                on overflow instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_serial_alu
    import bcd_alu_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NUM_DIGITS:0] op1,
    input  logic [4*NUM_DIGITS:0] op2,
    input  logic [2:0]            opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NUM_DIGITS:0] result,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int MAG_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t             state;
    logic [MAG_W-1:0]   a_sh;
    logic [MAG_W-1:0]   b_sh;
    logic [MAG_W-1:0]   res_mag;
    logic               carry;
    logic               op1_sign;
    logic               eff_sub;
    logic [IDX_W-1:0]   idx;

    op_t                dec_op;
    logic               op2_sign_eff;
    logic               eff_sub_in;
    logic               op_bad;
    logic [3:0]         add_a;
    logic [3:0]         add_b;
    logic [3:0]         sum;
    logic               cout;
    logic [MAG_W-1:0]   next_mag;
    logic [MAG_W-1:0]   final_mag;

    // Decode the incoming operation; SUB flips op2's sign before choosing add vs subtract.
    always_comb begin
        dec_op       = decode_op(opcode);
        op2_sign_eff = (dec_op == OP_SUB) ? ~op2[MAG_W] : op2[MAG_W];
        eff_sub_in   = (dec_op != OP_PASS) && (op1[MAG_W] != op2_sign_eff);
    end

    // Flag any non-BCD digit in either operand magnitude.
    always_comb begin
        op_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((op1[4*i +: 4] > BCD_NINE) || (op2[4*i +: 4] > BCD_NINE)) begin
                op_bad = 1'b1;
            end
        end
    end

    // Adder operand mux: CALC adds (or nine's-complements b), RECOMP complements the stored difference.
    always_comb begin
        add_a = a_sh[3:0];
        add_b = eff_sub ? nines_comp(b_sh[3:0]) : b_sh[3:0];
        if (state == RECOMP) begin
            add_a = nines_comp(res_mag[3:0]);
            add_b = 4'd0;
        end
    end

    bcd_digit_adder u_digit_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    // New digit enters at the MSD end so the magnitude is in place after NUM_DIGITS shifts.
    always_comb begin
        next_mag  = (res_mag >> 4) | (MAG_W'(sum) << (MAG_W - 4));
        final_mag = next_mag;
`ifdef BCD_SATURATE_EN
        if (!eff_sub && cout) begin
            final_mag = {NUM_DIGITS{BCD_NINE}};
        end
`endif
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_mag   <= '0;
            carry     <= 1'b0;
            op1_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        result   <= '0;
                        overflow <= 1'b0;
                        invalid  <= 1'b0;
                        idx      <= '0;
                        res_mag  <= '0;
                        op1_sign <= op1[MAG_W];
                        a_sh     <= op1[MAG_W-1:0];
                        // PASS streams op1 through the adder with a zero partner.
                        b_sh     <= (dec_op == OP_PASS) ? '0 : op2[MAG_W-1:0];
                        eff_sub  <= eff_sub_in;
                        carry    <= eff_sub_in;
                        if (op_bad) begin
                            invalid   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    carry   <= cout;
                    res_mag <= next_mag;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (eff_sub && !cout) begin
                            // Borrow out: magnitude is negative, recomplement it.
                            carry <= 1'b1;
                            state <= RECOMP;
                        end else begin
                            result    <= {op1_sign & (|final_mag), final_mag};
                            overflow  <= !eff_sub && cout;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RECOMP: begin
                    carry   <= cout;
                    res_mag <= next_mag;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        result    <= {~op1_sign & (|next_mag), next_mag};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_alu
//  Description : Scoreboard bench for bcd_serial_alu (NUM_DIGITS=4). The
//                driver pushes hand-computed expectations; a monitor pops and
//                compares result, flags and latency whenever out_valid rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_serial_alu;

    localparam int ND = 4;
    localparam int W  = 4 * ND + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        logic         inv;
        int           lat;
        int           stall;
        int           stamp;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         invalid;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    bcd_serial_alu #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] opc, input logic [W-1:0] er, input logic eo,
                         input logic ei, input int lat, input int stall);
        exp_t e;
        int   waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: in_ready stayed 0", name);
            return;
        end
        op1      = a;
        op2      = b;
        opcode   = opc;
        in_valid = 1'b1;
        e.res = er; e.ov = eo; e.inv = ei; e.lat = lat; e.stall = stall;
        e.stamp = cyc; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: result %h with no pending operation", result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"},   result,             e.res);
                    check({e.name, "_overflow"}, W'(overflow),       W'(e.ov));
                    check({e.name, "_invalid"},  W'(invalid),        W'(e.inv));
                    check({e.name, "_latency"},  W'(cyc - e.stamp),  W'(e.lat));
                    if (e.stall > 0) begin
                        out_ready = 1'b0;
                        for (int s = 0; s < e.stall; s++) begin
                            @(negedge clk);
                            check({e.name, "_stall_result"},   result,         e.res);
                            check({e.name, "_stall_valid"},    W'(out_valid),  W'(1));
                            check({e.name, "_stall_in_ready"}, W'(in_ready),   W'(0));
                        end
                        out_ready = 1'b1;
                    end
                end
                @(negedge clk);
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic [W-1:0] sat_exp;
`ifdef BCD_SATURATE_EN
        sat_exp = {1'b0, 16'h9999};
`else
        sat_exp = {1'b0, 16'h0000};
`endif
        rst      = 1'b1;
        in_valid = 1'b0;
        op1      = '0;
        op2      = '0;
        opcode   = 3'b000;
        repeat (2) @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_result",    result,        '0);
        check("reset_overflow",  W'(overflow),  W'(0));
        check("reset_invalid",   W'(invalid),   W'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_in_ready", W'(in_ready), W'(1));

        issue("add_basic",   {1'b0,16'h0123}, {1'b0,16'h0456}, 3'b000, {1'b0,16'h0579}, 1'b0, 1'b0, 5, 0);
        issue("sub_pos",     {1'b0,16'h0500}, {1'b0,16'h0123}, 3'b010, {1'b0,16'h0377}, 1'b0, 1'b0, 5, 0);
        issue("sub_recomp",  {1'b0,16'h0123}, {1'b0,16'h0500}, 3'b010, {1'b1,16'h0377}, 1'b0, 1'b0, 9, 0);
        issue("add_ovf",     {1'b0,16'h9999}, {1'b0,16'h0001}, 3'b000, sat_exp,          1'b1, 1'b0, 5, 0);
        issue("sub_zero",    {1'b0,16'h0042}, {1'b0,16'h0042}, 3'b010, {1'b0,16'h0000}, 1'b0, 1'b0, 5, 0);
        issue("add_negzero", {1'b1,16'h0042}, {1'b0,16'h0042}, 3'b000, {1'b0,16'h0000}, 1'b0, 1'b0, 5, 0);
        issue("add_negneg",  {1'b1,16'h0010}, {1'b1,16'h0015}, 3'b000, {1'b1,16'h0025}, 1'b0, 1'b0, 5, 0);
        issue("invalid_op1", {1'b0,16'h00A0}, {1'b0,16'h0001}, 3'b000, {1'b0,16'h0000}, 1'b0, 1'b1, 1, 0);
        issue("pass",        {1'b1,16'h1234}, {1'b0,16'h5678}, 3'b101, {1'b1,16'h1234}, 1'b0, 1'b0, 5, 0);
        issue("sub_negneg",  {1'b1,16'h0200}, {1'b1,16'h0050}, 3'b010, {1'b1,16'h0150}, 1'b0, 1'b0, 5, 0);
        issue("sub_mixed",   {1'b0,16'h0250}, {1'b1,16'h0300}, 3'b010, {1'b0,16'h0550}, 1'b0, 1'b0, 5, 0);
        issue("add_mix_neg", {1'b1,16'h0500}, {1'b0,16'h0123}, 3'b000, {1'b1,16'h0377}, 1'b0, 1'b0, 5, 0);
        issue("add_mix_rc",  {1'b0,16'h0123}, {1'b1,16'h0500}, 3'b000, {1'b1,16'h0377}, 1'b0, 1'b0, 9, 0);
        issue("add_carry",   {1'b0,16'h0958}, {1'b0,16'h0067}, 3'b000, {1'b0,16'h1025}, 1'b0, 1'b0, 5, 0);
        issue("stall",       {1'b0,16'h0001}, {1'b0,16'h0002}, 3'b000, {1'b0,16'h0003}, 1'b0, 1'b0, 5, 3);

        // Requests while busy must be ignored: only one result may appear.
        issue("busy_first",  {1'b0,16'h0011}, {1'b0,16'h0022}, 3'b000, {1'b0,16'h0033}, 1'b0, 1'b0, 5, 0);
        op1 = {1'b0,16'h7777}; op2 = {1'b0,16'h1111}; opcode = 3'b000; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        op1 = {1'b0,16'h0123}; op2 = {1'b0,16'h0456}; opcode = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midcalc_rst_out_valid", W'(out_valid), W'(0));
        check("midcalc_rst_result",    result,        '0);
        check("midcalc_rst_overflow",  W'(overflow),  W'(0));
        check("midcalc_rst_invalid",   W'(invalid),   W'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midcalc_rst_in_ready", W'(in_ready), W'(1));
        repeat (8) @(negedge clk);
        check("midcalc_rst_no_output", W'(out_valid), W'(0));

        issue("after_reset", {1'b0,16'h0999}, {1'b0,16'h0001}, 3'b000, {1'b0,16'h1000}, 1'b0, 1'b0, 5, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
